// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// State encoding, loss-counter width and PLL reset pulse length.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_STABLE = 2'd1,
        S_RUN    = 2'd2,
        S_LOST   = 2'd3
    } seq_state_e;

    localparam int unsigned LOST_CNT_W    = 8;
    localparam int unsigned PLL_RST_PULSE = 16;

    function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/clk_en_divider.sv
// One clock-enable channel: free-running divider gated by run, with a pending
// divide value that only takes effect at a period boundary.
module clk_en_divider #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 load_pend,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic [DIV_WIDTH-1:0] default_div,
    output logic                 clk_en
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
    logic [DIV_WIDTH-1:0] div_pend_q, div_pend_d;
    logic                 wrap;

    assign wrap = (cnt_q == div_act_q);

    always_comb begin
        cnt_d      = '0;
        div_pend_d = div_pend_q;
        div_act_d  = div_act_q;
        if (run && !wrap) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (load_pend) begin
            div_pend_d = div_in;
        end
        // Active value only changes on a period boundary so no period is cut short.
        if (!run || wrap) begin
            div_act_d = div_pend_q;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            div_act_q  <= default_div;
            div_pend_q <= default_div;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
        end
    end

    assign clk_en = run && (cnt_q == '0);

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL domain bring-up: lock synchroniser, stability qualifier, loss counter and
// clock-enable dividers. Optional lock watchdog under PLL_LOCK_WATCHDOG_EN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS       = 2,
    parameter int unsigned DIV_WIDTH          = 8,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned DEFAULT_DIV        = 0,
    parameter int unsigned WDOG_CYCLES        = 65536
) (
    input  logic                              clock_in,
    input  logic                              reset_n,
    input  logic                              pll_locked,
    input  logic [NUM_CHANNELS*DIV_WIDTH-1:0] div_value,
    input  logic                              div_load,
    output logic                              sys_reset_n,
    output logic                              ready,
    output logic [NUM_CHANNELS-1:0]           clk_en,
    output logic [LOST_CNT_W-1:0]             lock_lost_count,
    output logic                              pll_resetb,
    output logic                              lock_timeout
);

    localparam int unsigned STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

    seq_state_e            state_q, state_d;
    logic [1:0]            sync_q;
    logic                  locked_s;
    logic [STABLE_W-1:0]   stable_cnt_q, stable_cnt_d;
    logic [LOST_CNT_W-1:0] lost_cnt_q, lost_cnt_d;
    logic                  run;
    logic                  wdog_fire;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_WAIT;
            stable_cnt_q <= '0;
            lost_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            lost_cnt_q   <= lost_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = '0;
        lost_cnt_d   = lost_cnt_q;
        unique case (state_q)
            S_WAIT: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT;
                end else if (stable_cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                end else begin
                    stable_cnt_d = stable_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d    = S_LOST;
                    lost_cnt_d = sat_inc(lost_cnt_q);
                end
            end
            S_LOST: begin
                state_d = S_WAIT;
            end
        endcase
        // Watchdog restart overrides any qualification in progress.
        if (wdog_fire) begin
            state_d      = S_WAIT;
            stable_cnt_d = '0;
        end
    end

    always_comb begin
        run         = (state_q == S_RUN);
        sys_reset_n = run;
        ready       = run;
    end

    assign lock_lost_count = lost_cnt_q;

`ifdef PLL_LOCK_WATCHDOG_EN
    localparam int unsigned WDOG_W  = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam int unsigned PULSE_W = $clog2(PLL_RST_PULSE + 1);
    localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [PULSE_W-1:0] PULSE_LEN = PULSE_W'(PLL_RST_PULSE);

    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic               timeout_q, timeout_d;
    logic               wdog_active;

    always_comb begin
        wdog_active = (state_q == S_WAIT) || (state_q == S_STABLE);
        wdog_fire   = wdog_active && (wdog_q == WDOG_LAST);
        wdog_d      = '0;
        pulse_d     = '0;
        timeout_d   = timeout_q | wdog_fire;
        if (wdog_active && !wdog_fire) begin
            wdog_d = wdog_q + 1'b1;
        end
        if (wdog_fire) begin
            pulse_d = PULSE_LEN;
        end else if (pulse_q != '0) begin
            pulse_d = pulse_q - 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q    <= '0;
            pulse_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            pulse_q   <= pulse_d;
            timeout_q <= timeout_d;
        end
    end

    assign pll_resetb   = (pulse_q == '0);
    assign lock_timeout = timeout_q;
`else
    logic unused_wdog;

    assign unused_wdog  = ^WDOG_CYCLES;
    assign wdog_fire    = 1'b0;
    assign pll_resetb   = 1'b1;
    assign lock_timeout = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        clk_en_divider #(
            .DIV_WIDTH(DIV_WIDTH)
        ) u_div (
            .clock_in   (clock_in),
            .reset_n    (reset_n),
            .run        (run),
            .load_pend  (div_load),
            .div_in     (div_value[i*DIV_WIDTH +: DIV_WIDTH]),
            .default_div(DEF_DIV),
            .clk_en     (clk_en[i])
        );
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: per-cycle expectations are queued as
// stimulus is applied and compared against the DUT after each edge.
module tb_pll_lock_sequencer;

    logic        clock_in = 1'b0;
    logic        reset_n;
    logic        pll_locked;
    logic [15:0] div_value;
    logic        div_load;
    logic        sys_reset_n;
    logic        ready;
    logic [1:0]  clk_en;
    logic [7:0]  lock_lost_count;
    logic        pll_resetb;
    logic        lock_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [13:0] v;
    } exp_t;

    exp_t sb_q[$];

    pll_lock_sequencer #(
        .NUM_CHANNELS      (2),
        .DIV_WIDTH         (8),
        .LOCK_STABLE_CYCLES(4),
        .DEFAULT_DIV       (0),
        .WDOG_CYCLES       (32)
    ) dut (
        .clock_in       (clock_in),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .div_value      (div_value),
        .div_load       (div_load),
        .sys_reset_n    (sys_reset_n),
        .ready          (ready),
        .clk_en         (clk_en),
        .lock_lost_count(lock_lost_count),
        .pll_resetb     (pll_resetb),
        .lock_timeout   (lock_timeout)
    );

    always #5 clock_in = ~clock_in;

    function automatic logic [13:0] obs();
        return {sys_reset_n, ready, clk_en, lock_lost_count, pll_resetb, lock_timeout};
    endfunction

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic s, input logic [1:0] en,
                            input logic [7:0] cnt);
        exp_t e;
        e.tag = tag;
        e.v   = {s, s, en, cnt, 1'b1, 1'b0};
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [13:0] got;
        e   = sb_q.pop_front();
        got = obs();
        checks++;
        assert (got === e.v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", e.tag, got, e.v);
        end
    endtask

    // Expectation for the state after the next clock edge.
    task automatic cyc(input string tag, input logic s, input logic [1:0] en,
                       input logic [7:0] cnt);
        push_exp(tag, s, en, cnt);
        tick();
        pop_check();
    endtask

    // Expectation for the present state, no clock edge.
    task automatic now(input string tag, input logic s, input logic [1:0] en,
                       input logic [7:0] cnt);
        push_exp(tag, s, en, cnt);
        pop_check();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (sys_reset_n !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        assert (sys_reset_n === 1'b1) else begin
            errors++;
            $error("FAIL %s observed sys_reset_n=%b expected 1 within 20 cycles", tag, sys_reset_n);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        div_value  = '0;
        div_load   = 1'b0;
        #2;
        now("reset_values", 1'b0, 2'b00, 8'd0);
        tick();
        tick();

        // Clean lock: release after edge LOCK_STABLE_CYCLES+3 = 7.
        reset_n    = 1'b1;
        pll_locked = 1'b1;
        for (int i = 1; i <= 6; i++) cyc("lock_wait", 1'b0, 2'b00, 8'd0);
        cyc("release_edge7", 1'b1, 2'b11, 8'd0);
        cyc("run_div0_a", 1'b1, 2'b11, 8'd0);
        cyc("run_div0_b", 1'b1, 2'b11, 8'd0);

        // Asynchronous reset with no clock edge.
        reset_n = 1'b0;
        #2;
        now("async_reset", 1'b0, 2'b00, 8'd0);
        tick();
        reset_n    = 1'b1;
        pll_locked = 1'b0;

        // ch0=2, ch1=0 loaded before lock, then a one-cycle lock glitch in S_STABLE.
        div_value = {8'd0, 8'd2};
        div_load  = 1'b1;
        cyc("load_pre_lock", 1'b0, 2'b00, 8'd0);
        div_load   = 1'b0;
        pll_locked = 1'b1;
        cyc("glitch_e1", 1'b0, 2'b00, 8'd0);
        cyc("glitch_e2", 1'b0, 2'b00, 8'd0);
        cyc("glitch_e3", 1'b0, 2'b00, 8'd0);
        pll_locked = 1'b0;
        cyc("glitch_e4", 1'b0, 2'b00, 8'd0);
        pll_locked = 1'b1;
        for (int i = 5; i <= 10; i++) cyc("glitch_hold", 1'b0, 2'b00, 8'd0);
        cyc("glitch_release_e11", 1'b1, 2'b11, 8'd0);
        cyc("div2_a", 1'b1, 2'b10, 8'd0);
        cyc("div2_b", 1'b1, 2'b10, 8'd0);
        cyc("div2_c", 1'b1, 2'b11, 8'd0);
        cyc("div2_d", 1'b1, 2'b10, 8'd0);
        cyc("div2_e", 1'b1, 2'b10, 8'd0);
        cyc("div2_f", 1'b1, 2'b11, 8'd0);

        // ch0 at div 3, reprogrammed to 1 while cnt=1.
        pll_locked = 1'b0;
        do_reset();
        div_value = {8'd0, 8'd3};
        div_load  = 1'b1;
        cyc("load_div3", 1'b0, 2'b00, 8'd0);
        div_load   = 1'b0;
        pll_locked = 1'b1;
        for (int i = 1; i <= 6; i++) cyc("div3_lock_wait", 1'b0, 2'b00, 8'd0);
        cyc("div3_release", 1'b1, 2'b11, 8'd0);
        cyc("div3_cnt1", 1'b1, 2'b10, 8'd0);
        div_value = {8'd0, 8'd1};
        div_load  = 1'b1;
        cyc("reload_cnt2", 1'b1, 2'b10, 8'd0);
        div_load = 1'b0;
        cyc("reload_cnt3", 1'b1, 2'b10, 8'd0);
        cyc("reload_wrap", 1'b1, 2'b11, 8'd0);
        cyc("div1_a", 1'b1, 2'b10, 8'd0);
        cyc("div1_b", 1'b1, 2'b11, 8'd0);
        cyc("div1_c", 1'b1, 2'b10, 8'd0);
        cyc("div1_d", 1'b1, 2'b11, 8'd0);

        // Loss of lock from S_RUN, then saturation of the loss counter.
        pll_locked = 1'b0;
        do_reset();
        div_value  = '0;
        pll_locked = 1'b1;
        wait_run("run_before_loss");
        pll_locked = 1'b0;
        cyc("loss_k", 1'b1, 2'b11, 8'd0);
        cyc("loss_k1", 1'b1, 2'b11, 8'd0);
        cyc("loss_k2", 1'b0, 2'b00, 8'd1);
        cyc("loss_wait", 1'b0, 2'b00, 8'd1);
        for (int i = 0; i < 254; i++) begin
            pll_locked = 1'b1;
            wait_run("relock");
            pll_locked = 1'b0;
            tick();
            tick();
            tick();
        end
        now("lost_count_255", 1'b0, 2'b00, 8'd255);
        pll_locked = 1'b1;
        wait_run("relock_sat");
        pll_locked = 1'b0;
        tick();
        tick();
        cyc("lost_count_sat", 1'b0, 2'b00, 8'd255);

`ifdef PLL_LOCK_WATCHDOG_EN
        begin
            int n;
            do_reset();
            n = 0;
            while (pll_resetb !== 1'b0 && n < 40) begin
                tick();
                n++;
            end
            checks++;
            assert (pll_resetb === 1'b0 && lock_timeout === 1'b1) else begin
                errors++;
                $error("FAIL wdog_fire observed resetb=%b timeout=%b expected 0/1",
                       pll_resetb, lock_timeout);
            end
            n = 0;
            while (pll_resetb !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            checks++;
            assert (n == 16 && lock_timeout === 1'b1) else begin
                errors++;
                $error("FAIL wdog_pulse observed low=%0d timeout=%b expected 16/1",
                       n, lock_timeout);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Parametrised clock-domain bring-up block for the PLL output domain.
- Synchronises the raw PLL lock flag and requires lock to be continuously stable before releasing the domain reset.
- Detects loss of lock and counts it.
- Generates NUM_CHANNELS independent, runtime-reprogrammable clock-enable strobes for slower sub-domains. This avoids adding extra PLLs.
- Sits directly after the PLL primitive wrapper; its outputs feed the processor core and peripherals.

Parameters:
NUM_CHANNELS, 2, number of clock-enable channels (1..8)
DIV_WIDTH, 8, width of each channel divide value
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release (>=1)
DEFAULT_DIV, 0, divide value loaded into every channel at reset
WDOG_CYCLES, 65536, lock watchdog timeout (used only with the optional feature)

Ports:
clock_in  in  1  PLL output clock; the single clock of the block
reset_n  in  1  asynchronous active-low reset
pll_locked  in  1  raw PLL lock flag, asynchronous to clock_in
div_value  in  NUM_CHANNELS*DIV_WIDTH  packed divide values; channel i at [i*DIV_WIDTH +: DIV_WIDTH]
div_load  in  1  single-cycle strobe; samples div_value into the pending registers
sys_reset_n  out  1  downstream active-low reset, high only in S_RUN
ready  out  1  equal to sys_reset_n
clk_en  out  NUM_CHANNELS  per-channel enable strobes
lock_lost_count  out  8  saturating loss-of-lock counter
pll_resetb  out  1  PLL RESETB drive (active low)
lock_timeout  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: one clock (clock_in); reset is asynchronous and active-low (reset_n).
- Reset values: state S_WAIT, sync flops 0, stable_cnt 0, all div counters 0, active and pending div = DEFAULT_DIV, lock_lost_count 0, lock_timeout 0.
- Reset output values: sys_reset_n 0, ready 0, clk_en all 0, pll_resetb 1.
- Synchroniser: pll_locked passes through 2 flops to give locked_s.
- State machine: Moore outputs decoded from the state register.
  - S_WAIT: stable_cnt=0. If locked_s -> S_STABLE.
  - S_STABLE: if !locked_s -> S_WAIT (stable_cnt cleared). Else if stable_cnt==LOCK_STABLE_CYCLES-1 -> S_RUN. Else stable_cnt++.
  - S_RUN: sys_reset_n=1. If !locked_s -> S_LOST and lock_lost_count++ (saturates at 255).
  - S_LOST: sys_reset_n=0; unconditionally -> S_WAIT next cycle.
- Release latency: pll_locked high before edge 1 gives sys_reset_n=1 after edge LOCK_STABLE_CYCLES+3.
- Loss latency: pll_locked low before edge k gives sys_reset_n=0 after edge k+2.
- stable_cnt width: $clog2(LOCK_STABLE_CYCLES+1).
- Dividers, per channel i:
  - Counter cnt_i, DIV_WIDTH bits, held at 0 outside S_RUN.
  - In S_RUN: cnt_i = (cnt_i==div_act_i) ? 0 : cnt_i+1.
  - clk_en[i] = (state==S_RUN) && (cnt_i==0), so the period is div_act_i+1 cycles. div 0 gives clk_en constantly high.
  - The first strobe fires in the first S_RUN cycle.
- Reprogramming:
  - div_load copies div_value into div_pend on the next edge.
  - div_act_i <= div_pend_i at that channel's wrap edge (cnt_i==div_act_i), or on any edge outside S_RUN. The period in flight is never truncated or extended.
  - div_load coinciding with a wrap: the pending update lands this edge and the active update happens at the following wrap.
  - A second div_load before a wrap overwrites pending; the last value wins.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).

Optional Feature:
Macro PLL_LOCK_WATCHDOG_EN.
- Defined:
  - A watchdog counter runs in S_WAIT and S_STABLE and clears in S_RUN.
  - On reaching WDOG_CYCLES-1: lock_timeout is set (sticky until reset_n), pll_resetb is driven 0 for 16 cycles, the counter clears and the FSM returns to S_WAIT.
  - pll_resetb is 1 otherwise.
- Not defined: pll_resetb tied 1, lock_timeout tied 0, no watchdog logic.

Decomposition:
- Package pll_seq_pkg:
  - state enum (S_WAIT, S_STABLE, S_RUN, S_LOST), 2 bits
  - LOST_CNT_W=8
  - PLL_RST_PULSE=16
- Sub-module clk_en_divider (one per channel, generate loop): DIV_WIDTH parameter; ports clock_in, reset_n, run, load_pend, div_in, default div, clk_en.

Test Plan:
1. LOCK_STABLE_CYCLES=4; pll_locked rises before edge 1 -> sys_reset_n and ready rise after edge 7; clk_en[0]=1 (DEFAULT_DIV=0) from the same cycle.
2. pll_locked high 3 cycles, low 1 cycle, then high during S_STABLE -> FSM returns to S_WAIT, stable count restarts, release delayed; lock_lost_count stays 0.
3. In S_RUN, pll_locked falls before edge k -> sys_reset_n=0 and clk_en=0 after edge k+2; lock_lost_count=1; 256 losses -> count saturates at 255.
4. div_value ch0=2, ch1=0 loaded before lock -> in S_RUN clk_en[0] pulses every 3rd cycle, clk_en[1] constant 1.
5. ch0 running at div 3; div_load of 1 at cnt=1 -> current 4-cycle period completes, then a strobe every 2 cycles; no short pulse gap.
6. reset_n pulsed low mid-S_RUN -> all outputs go to reset values without a clock edge. With PLL_LOCK_WATCHDOG_EN and WDOG_CYCLES=32, no lock -> lock_timeout=1 and pll_resetb low for exactly 16 cycles.
